// File: rtl/param_gate_unit.sv
// Masked N-channel bitwise gate (AND/OR/NAND/NOR/XOR/XNOR/NOT) with a sticky illegal-mode flag.
// One-cycle registered result; in_ready drops only while a result is held against out_ready=0.
module param_gate_unit #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [NUM_IN-1:0]       in_mask,
   input  logic [2:0]              mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err,
   output logic [CNT_W-1:0]        txn_count
);

   typedef enum logic [2:0] {
      MODE_AND  = 3'b000,
      MODE_OR   = 3'b001,
      MODE_NAND = 3'b010,
      MODE_NOR  = 3'b011,
      MODE_XOR  = 3'b100,
      MODE_XNOR = 3'b101,
      MODE_NOT  = 3'b110,
      MODE_ILL  = 3'b111
   } mode_e;

   logic [WIDTH-1:0] and_red;
   logic [WIDTH-1:0] or_red;
   logic [WIDTH-1:0] xor_red;
   logic [WIDTH-1:0] not_first;
   logic             found;
   logic [WIDTH-1:0] result;
   logic             accept;

   // Masked channels leave each reduction at its identity value.
   always_comb begin
      and_red   = '1;
      or_red    = '0;
      xor_red   = '0;
      not_first = '1;
      found     = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_mask[k]) begin
            and_red = and_red & in_bus[k*WIDTH +: WIDTH];
            or_red  = or_red  | in_bus[k*WIDTH +: WIDTH];
            xor_red = xor_red ^ in_bus[k*WIDTH +: WIDTH];
            if (!found) begin
               not_first = ~in_bus[k*WIDTH +: WIDTH];
               found     = 1'b1;
            end
         end
      end
   end

   always_comb begin
      result = '0;
      case (mode_e'(mode))
         MODE_AND:  result = and_red;
         MODE_OR:   result = or_red;
         MODE_NAND: result = ~and_red;
         MODE_NOR:  result = ~or_red;
         MODE_XOR:  result = xor_red;
         MODE_XNOR: result = ~xor_red;
         MODE_NOT:  result = not_first;
         default:   result = '0;
      endcase
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         txn_count <= '0;
      end else begin
         if (accept) begin
            out       <= result;
            out_valid <= 1'b1;
            txn_count <= txn_count + CNT_W'(1);
            if (mode == MODE_ILL) begin
               err <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_param_gate_unit.sv
// Randomized and directed checks of param_gate_unit against a queue-based reference model.
module tb_param_gate_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_bus;
   logic [3:0]  in_mask;
   logic [2:0]  mode;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready,  in_ready4;
   logic [7:0]  out,       out4;
   logic        out_valid, out_valid4;
   logic        err,       err4;
   logic [15:0] txn_count;
   logic [3:0]  txn_count4;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0]  exp_out;
   logic        exp_valid;
   logic        exp_err;
   int unsigned exp_cnt;
   logic        exp_rdy;
   logic        rdy_seen, rdy4_seen;

   param_gate_unit dut (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_mask(in_mask), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
      .out_ready(out_ready), .err(err), .txn_count(txn_count)
   );

   param_gate_unit #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_mask(in_mask), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready4), .out(out4), .out_valid(out_valid4),
      .out_ready(out_ready), .err(err4), .txn_count(txn_count4)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_gate(input logic [31:0] b, input logic [3:0] m,
                                           input logic [2:0] md);
      logic [7:0] vals[$];
      logic [7:0] a, o, x;
      a = 8'hFF; o = 8'h00; x = 8'h00;
      for (int k = 0; k < 4; k++)
         if (m[k]) vals.push_back(b[k*8 +: 8]);
      foreach (vals[i]) begin
         a = a & vals[i];
         o = o | vals[i];
         x = x ^ vals[i];
      end
      case (md)
         3'd0: return a;
         3'd1: return o;
         3'd2: return ~a;
         3'd3: return ~o;
         3'd4: return x;
         3'd5: return ~x;
         3'd6: return (vals.size() > 0) ? ~vals[0] : 8'hFF;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      exp_out = 8'h00; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 0;
   endtask

   // Called at posedge+1; returns at the following posedge+1 with the model advanced.
   task automatic step(input logic v, input logic [31:0] b, input logic [3:0] m,
                       input logic [2:0] md, input logic ordy);
      logic acc;
      in_valid = v; in_bus = b; in_mask = m; mode = md; out_ready = ordy;
      #1;
      exp_rdy   = !exp_valid || ordy;
      rdy_seen  = in_ready;
      rdy4_seen = in_ready4;
      acc = v && exp_rdy && rst_n;
      @(posedge clk);
      #1;
      if (acc) begin
         exp_out   = ref_gate(b, m, md);
         exp_valid = 1'b1;
         exp_cnt   = exp_cnt + 1;
         if (md == 3'b111) exp_err = 1'b1;
      end else if (ordy && rst_n) begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_bus = '0; in_mask = '0; mode = '0;
      model_reset();
      @(posedge clk); #1;
      vectors++;
      if ({out, out_valid, err, txn_count} !== 26'd0) begin
         miscompares++;
         $display("FAIL reset_state: got out=%h vld=%b err=%b cnt=%0d required all zero",
                  out, out_valid, err, txn_count);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, $urandom, 4'hF, 3'd1, 1'b1);
         vectors++;
         if (rdy_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 1", rdy_seen);
         end
         vectors++;
         if (txn_count !== 16'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_accept: got cnt=%0d vld=%b required 0/0", txn_count, out_valid);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      step(1'b1, 32'hFFFF_F0FF, 4'b1111, 3'b010, 1'b1);
      vectors++;
      if (out !== 8'h0F || out_valid !== 1'b1 || txn_count !== 16'd1) begin
         miscompares++;
         $display("FAIL nand_first: got out=%h vld=%b cnt=%0d required 0f/1/1",
                  out, out_valid, txn_count);
      end
      step(1'b1, 32'h220F_11AA, 4'b0101, 3'b100, 1'b1);
      vectors++;
      if (out !== 8'hA5 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL xor_masked: got out=%h vld=%b required a5/1", out, out_valid);
      end
      step(1'b1, $urandom, 4'b0000, 3'b110, 1'b1);
      vectors++;
      if (out !== 8'hFF) begin
         miscompares++;
         $display("FAIL not_empty_mask: got %h required ff", out);
      end
      step(1'b1, $urandom, 4'b0000, 3'b010, 1'b1);
      vectors++;
      if (out !== 8'h00) begin
         miscompares++;
         $display("FAIL nand_empty_mask: got %h required 00", out);
      end
      step(1'b0, $urandom, 4'hF, 3'b000, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || out !== 8'h00) begin
         miscompares++;
         $display("FAIL consume_only: got vld=%b out=%h required 0/00", out_valid, out);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  held;
      logic [15:0] held_cnt;
      step(1'b1, $urandom, 4'b1011, 3'd4, 1'b0);
      held = out; held_cnt = txn_count;
      vectors++;
      if (out !== exp_out || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_load: got out=%h vld=%b required %h/1", out, out_valid, exp_out);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, $urandom, $urandom, $urandom_range(0, 6), 1'b0);
         vectors++;
         if (rdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_in_ready: got %b required 0", rdy_seen);
         end
         vectors++;
         if (out !== held || out_valid !== 1'b1 || txn_count !== held_cnt) begin
            miscompares++;
            $display("FAIL bp_hold: got out=%h vld=%b cnt=%0d required %h/1/%0d",
                     out, out_valid, txn_count, held, held_cnt);
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, $urandom, $urandom, $urandom_range(0, 6), 1'b1);
         vectors++;
         if (rdy_seen !== 1'b1 || out !== exp_out || out_valid !== 1'b1 ||
             txn_count !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL back_to_back: got rdy=%b out=%h vld=%b cnt=%0d required 1/%h/1/%0d",
                     rdy_seen, out, out_valid, txn_count, exp_out, exp_cnt);
         end
      end
   endtask

   task automatic test_illegal();
      step(1'b1, $urandom, 4'hF, 3'b111, 1'b1);
      vectors++;
      if (out !== 8'h00 || out_valid !== 1'b1 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_mode: got out=%h vld=%b err=%b required 00/1/1", out, out_valid, err);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, $urandom, $urandom, $urandom_range(0, 6), 1'b1);
         vectors++;
         if (err !== 1'b1 || out !== exp_out) begin
            miscompares++;
            $display("FAIL err_sticky: got err=%b out=%h required 1/%h", err, out, exp_out);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom_range(0, 7),
              ($urandom_range(0, 2) != 0));
         vectors++;
         if (rdy_seen !== exp_rdy || rdy4_seen !== exp_rdy) begin
            miscompares++;
            $display("FAIL rand_in_ready: got %b/%b required %b", rdy_seen, rdy4_seen, exp_rdy);
         end
         vectors++;
         if (out_valid !== exp_valid || out_valid4 !== exp_valid ||
             (exp_valid && (out !== exp_out || out4 !== exp_out))) begin
            miscompares++;
            $display("FAIL rand_out: got out=%h vld=%b required %h/%b", out, out_valid, exp_out, exp_valid);
         end
         vectors++;
         if (err !== exp_err || err4 !== exp_err || txn_count !== 16'(exp_cnt) ||
             txn_count4 !== 4'(exp_cnt)) begin
            miscompares++;
            $display("FAIL rand_status: got err=%b cnt=%0d cnt4=%0d required %b/%0d",
                     err, txn_count, txn_count4, exp_err, exp_cnt);
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, $urandom, 4'hF, 3'b111, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset: got vld=%b err=%b required 1/1", out_valid, err);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out, out_valid, err, txn_count} !== 26'd0 || txn_count4 !== 4'd0) begin
         miscompares++;
         $display("FAIL async_reset: got out=%h vld=%b err=%b cnt=%0d required all zero",
                  out, out_valid, err, txn_count);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, $urandom, 4'hF, 3'd0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || out !== 8'h00) begin
         miscompares++;
         $display("FAIL discard_pending: got vld=%b out=%h required 0/00", out_valid, out);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 17; i++)
         step(1'b1, $urandom, $urandom, $urandom_range(0, 6), 1'b1);
      vectors++;
      if (txn_count4 !== 4'd1 || txn_count !== 16'd17) begin
         miscompares++;
         $display("FAIL count_wrap: got cnt4=%0d cnt=%0d required 1/17", txn_count4, txn_count);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_illegal();
      test_random();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/param_gate_unit.md
PARAM_GATE_UNIT -- requirements
Module: param_gate_unit

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each operand and of the result; legal range 1..32.
REQ-002 Parameter NUM_IN, default 4: number of operand channels; legal range 2..8.
REQ-003 Parameter CNT_W, default 16: width of the transaction counter.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port in_bus  input  NUM_IN*WIDTH  flattened operands; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_mask  input  NUM_IN  channel k participates only when in_mask[k]=1.
REQ-008 Port mode  input  3  operation select, sampled with in_bus.
REQ-009 Port in_valid  input  1  producer presents in_bus/in_mask/mode.
REQ-010 Port in_ready  output  1  unit accepts a transaction this cycle.
REQ-011 Port out  output  WIDTH  registered result.
REQ-012 Port out_valid  output  1  out holds an unconsumed result.
REQ-013 Port out_ready  input  1  consumer takes out this cycle.
REQ-014 Port err  output  1  sticky illegal-mode flag.
REQ-015 Port txn_count  output  CNT_W  number of accepted transactions.

Function
REQ-016 Mode encoding: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT (bitwise inverse of the lowest-index unmasked channel), 111 illegal.
REQ-017 Reduction is bitwise across unmasked channels; masked channels contribute the identity element (all-ones for AND/NAND, all-zeros for OR/NOR/XOR/XNOR).
REQ-018 NAND/NOR/XNOR results are the bitwise inverse of the AND/OR/XOR reduction over the same unmasked set.
REQ-019 in_mask all zero: AND yields all-ones, NAND all-zeros, OR/XOR all-zeros, NOR/XNOR all-ones, NOT all-ones.
REQ-020 Acceptance occurs in a cycle where in_valid=1 and in_ready=1.
REQ-021 in_ready is combinational: in_ready = (out_valid==0) OR (out_ready==1).
REQ-022 Latency: result of an accepted transaction appears on out with out_valid=1 on the first rising edge after acceptance (one cycle).
REQ-023 While out_valid=1 and out_ready=0, out and out_valid hold stable; no new transaction is accepted.
REQ-024 Simultaneous consume and accept (out_valid=1, out_ready=1, in_valid=1): out updates to the new result and out_valid stays 1 with no bubble.
REQ-025 Consume without accept: out_valid clears on the next edge; out retains its last value.
REQ-026 Mode 111 accepted: the transaction completes normally with out = all-zeros; err sets to 1 on the same edge and stays set until reset.
REQ-027 txn_count increments by one per accepted transaction, including illegal-mode ones, and wraps from 2^CNT_W-1 to 0.
REQ-028 in_bus, in_mask and mode are ignored in cycles without acceptance.

Reset
REQ-029 rst_n=0 forces out=0, out_valid=0, err=0, txn_count=0 immediately, independent of clk.
REQ-030 Reset asserted while out_valid=1 discards the pending result; no result is delivered after release.
REQ-031 in_ready evaluates to 1 during reset; transactions offered while rst_n=0 are not accepted and not counted.
REQ-032 First acceptance is possible on the first rising edge with rst_n=1.

Verification
REQ-033 Defaults, mask=4'b1111, mode=010, in_bus channels 8'hFF,8'hF0,8'hFF,8'hFF, out_ready=1 -> one cycle later out=8'h0F, out_valid=1, txn_count=1.
REQ-034 mask=4'b0101, mode=100, channels 0..3 = 8'hAA,8'h11,8'h0F,8'h22 -> out=8'hA5 (channels 1 and 3 ignored).
REQ-035 out_ready=0 for 3 cycles after a result with in_valid=1 throughout -> in_ready=0, out stable, txn_count unchanged; out_ready=1 -> back-to-back accept, no bubble.
REQ-036 mode=111 accepted -> out=8'h00, out_valid=1, err=1; later legal modes leave err=1 until rst_n pulses low.
REQ-037 CNT_W=4, 17 accepted transactions -> txn_count=1 after wrap.
REQ-038 rst_n low mid-clock with out_valid=1 -> out_valid=0, out=0, err=0, txn_count=0 without waiting for a clk edge.
